// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise, glitch-filter, deserialise and decode E0/F0/E1 prefixes into ps2_key.
// Optional macro PS2_KBD_TIMEOUT_EN aborts a stalled partial frame after TIMEOUT_CYCLES clocks.
module ps2_kbd_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

  logic [1:0] r_clkSync;
  logic [1:0] r_datSync;
  logic       r_clkFilt;
  logic       r_datFilt;
  logic [7:0] r_clkCnt;
  logic [7:0] r_datCnt;
  logic       r_clkFiltPrev;
  logic       w_fall;

  state_t     r_state;
  state_t     w_stateNext;
  logic [2:0] r_bitIdx;
  logic [2:0] w_bitIdxNext;
  logic [7:0] r_shift;
  logic [7:0] w_shiftNext;
  logic       r_parity;
  logic       w_parityNext;
  logic       w_frameDone;
  logic       w_frameOk;
  logic       r_frameDone;
  logic       r_frameOk;
  logic       w_timeout;

  logic       r_ext;
  logic       r_rel;
  logic [2:0] r_skip;

  // Idle-high reset value keeps the line from looking like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clkSync <= 2'b11;
      r_datSync <= 2'b11;
    end else begin
      r_clkSync <= {r_clkSync[0], ps2_clk_in};
      r_datSync <= {r_datSync[0], ps2_dat_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clkFilt <= 1'b1;
      r_clkCnt  <= 8'd0;
    end else if (r_clkSync[1] == r_clkFilt) begin
      r_clkCnt  <= 8'd0;
    end else if (r_clkCnt == FILT_LAST) begin
      r_clkFilt <= r_clkSync[1];
      r_clkCnt  <= 8'd0;
    end else begin
      r_clkCnt  <= r_clkCnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_datFilt <= 1'b1;
      r_datCnt  <= 8'd0;
    end else if (r_datSync[1] == r_datFilt) begin
      r_datCnt  <= 8'd0;
    end else if (r_datCnt == FILT_LAST) begin
      r_datFilt <= r_datSync[1];
      r_datCnt  <= 8'd0;
    end else begin
      r_datCnt  <= r_datCnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clkFiltPrev <= 1'b1;
    end else begin
      r_clkFiltPrev <= r_clkFilt;
    end
  end

  assign w_fall = r_clkFiltPrev & ~r_clkFilt;

`ifdef PS2_KBD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_toCnt;

  always_ff @(posedge clk) begin
    if (reset || w_fall || (r_state == S_IDLE)) begin
      r_toCnt <= '0;
    end else begin
      r_toCnt <= r_toCnt + TO_W'(1);
    end
  end

  assign w_timeout = (r_state != S_IDLE) && (r_toCnt == TO_W'(TIMEOUT_CYCLES));
`else
  logic w_unusedTimeout;

  assign w_unusedTimeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bitIdx    <= 3'd0;
      r_shift     <= 8'd0;
      r_parity    <= 1'b0;
      r_frameDone <= 1'b0;
      r_frameOk   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_bitIdx    <= w_bitIdxNext;
      r_shift     <= w_shiftNext;
      r_parity    <= w_parityNext;
      r_frameDone <= w_frameDone;
      r_frameOk   <= w_frameOk;
    end
  end

  // A timeout is reported as a failed frame so it shares the error path below.
  always_comb begin
    w_stateNext  = r_state;
    w_bitIdxNext = r_bitIdx;
    w_shiftNext  = r_shift;
    w_parityNext = r_parity;
    w_frameDone  = 1'b0;
    w_frameOk    = 1'b0;
    if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!r_datFilt) begin
            w_stateNext  = S_DATA;
            w_bitIdxNext = 3'd0;
          end
        end
        S_DATA: begin
          w_shiftNext  = {r_datFilt, r_shift[7:1]};
          w_bitIdxNext = r_bitIdx + 3'd1;
          if (r_bitIdx == 3'd7) begin
            w_stateNext = S_PARITY;
          end
        end
        S_PARITY: begin
          w_parityNext = r_datFilt;
          w_stateNext  = S_STOP;
        end
        S_STOP: begin
          w_frameDone = 1'b1;
          w_frameOk   = r_datFilt & ((^r_shift) ^ r_parity);
          w_stateNext = S_IDLE;
        end
        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end else if (w_timeout) begin
      w_stateNext = S_IDLE;
      w_frameDone = 1'b1;
      w_frameOk   = 1'b0;
    end
  end

  // E1 swallows the rest of the 8-byte Pause sequence via the skip counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_key <= 11'h000;
      err     <= 1'b0;
      r_ext   <= 1'b0;
      r_rel   <= 1'b0;
      r_skip  <= 3'd0;
    end else begin
      err <= 1'b0;
      if (r_frameDone) begin
        if (!r_frameOk) begin
          err    <= 1'b1;
          r_ext  <= 1'b0;
          r_rel  <= 1'b0;
          r_skip <= 3'd0;
        end else if (r_skip != 3'd0) begin
          r_skip <= r_skip - 3'd1;
        end else if (r_shift == 8'hE1) begin
          r_skip <= 3'd7;
        end else if (r_shift == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_rel <= 1'b1;
        end else begin
          ps2_key <= {~ps2_key[10], ~r_rel, r_ext, r_shift};
          r_ext   <= 1'b0;
          r_rel   <= 1'b0;
        end
      end
    end
  end

endmodule
